// File: rtl/dmem_pkg.sv
// ============================================================================
// dmem_pkg : opcodes, FSM states and op classification for dmem_responder
// Rev 1.0
// ============================================================================
`default_nettype none

package dmem_pkg;

  localparam logic [5:0] OP_LB  = 6'd0;
  localparam logic [5:0] OP_LH  = 6'd1;
  localparam logic [5:0] OP_LW  = 6'd2;
  localparam logic [5:0] OP_LBU = 6'd3;
  localparam logic [5:0] OP_LHU = 6'd4;
  localparam logic [5:0] OP_SB  = 6'd15;
  localparam logic [5:0] OP_SH  = 6'd16;
  localparam logic [5:0] OP_SW  = 6'd17;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  function automatic logic is_half(input logic [5:0] op);
    return (op == OP_LH) || (op == OP_LHU) || (op == OP_SH);
  endfunction

  function automatic logic is_word(input logic [5:0] op);
    return (op == OP_LW) || (op == OP_SW);
  endfunction

  function automatic logic is_store(input logic [5:0] op);
    return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
  endfunction

  function automatic logic is_legal(input logic [5:0] op);
    return (op == OP_LB) || (op == OP_LBU) || (op == OP_SB) ||
           is_half(op) || is_word(op);
  endfunction

endpackage

`default_nettype wire

// File: rtl/dmem_lane_align.sv
// ============================================================================
// dmem_lane_align : byte-lane steering for stores and right-justify for loads
// Rev 1.0
// ============================================================================
`default_nettype none

module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [5:0]  op_i,
  input  logic [1:0]  addr_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] raw_word_i,
  output logic [3:0]  be_o,
  output logic [31:0] store_word_o,
  output logic [31:0] load_word_o,
  output logic        misalign_o
);

  always_comb begin
    be_o = 4'b0000;
    case (op_i)
      OP_SB:   be_o = 4'b0001 << addr_i;
      OP_SH:   be_o = addr_i[1] ? 4'b1100 : 4'b0011;
      OP_SW:   be_o = 4'b1111;
      default: be_o = 4'b0000;
    endcase
  end

  // Aligned halves sit at offset 0 or 2, so one shift serves SB, SH and SW.
  assign store_word_o = wdata_i << {addr_i, 3'b000};
  assign load_word_o  = raw_word_i >> {addr_i, 3'b000};
  assign misalign_o   = (is_half(op_i) && addr_i[0]) ||
                        (is_word(op_i) && (addr_i != 2'b00));

endmodule

`default_nettype wire

// File: rtl/dmem_responder.sv
// ============================================================================
// dmem_responder : single-outstanding load/store responder with wait states
// Rev 1.0
// ============================================================================
`default_nettype none

module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [5:0]  req_op,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int          IDX_W     = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [31:0] DEPTH_LIM = 32'(DEPTH_WORDS);
  localparam logic [2:0]  WAIT_INIT = 3'(WAIT_STATES);

  state_e            state_q;
  logic [2:0]        cnt_q;
  logic [5:0]        op_q;
  logic [1:0]        off_q;
  logic [IDX_W-1:0]  idx_q;
  logic [31:0]       wdata_q;
  logic              req_ready_q;
  logic              rsp_valid_q;
  logic              rsp_err_q;
  logic [31:0]       rsp_rdata_q;
  logic [31:0]       mem_q [DEPTH_WORDS];

  logic [5:0]  align_op;
  logic [1:0]  align_off;
  logic [3:0]  be;
  logic [31:0] store_word;
  logic [31:0] load_word;
  logic        misalign;
  logic        req_err;
  logic        access;

  // In IDLE the aligner checks the incoming request; afterwards it serves the captured one.
  assign align_op  = (state_q == ST_IDLE) ? req_op         : op_q;
  assign align_off = (state_q == ST_IDLE) ? req_addr[1:0]  : off_q;

  dmem_lane_align u_align (
    .op_i         (align_op),
    .addr_i       (align_off),
    .wdata_i      (wdata_q),
    .raw_word_i   (mem_q[idx_q]),
    .be_o         (be),
    .store_word_o (store_word),
    .load_word_o  (load_word),
    .misalign_o   (misalign)
  );

  assign req_err = !is_legal(req_op) || misalign ||
                   ({2'b00, req_addr[31:2]} >= DEPTH_LIM);
  assign access  = (state_q == ST_WAIT) && (cnt_q == 3'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 3'd0;
      op_q        <= 6'd0;
      off_q       <= 2'd0;
      idx_q       <= '0;
      wdata_q     <= 32'd0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= 32'd0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (req_valid && req_ready_q) begin
            op_q        <= req_op;
            off_q       <= req_addr[1:0];
            idx_q       <= req_addr[IDX_W+1:2];
            wdata_q     <= req_wdata;
            req_ready_q <= 1'b0;
            if (req_err) begin
              state_q     <= ST_RESP;
              rsp_valid_q <= 1'b1;
              rsp_err_q   <= 1'b1;
              rsp_rdata_q <= 32'd0;
            end else begin
              state_q <= ST_WAIT;
              cnt_q   <= WAIT_INIT;
            end
          end
        end
        ST_WAIT: begin
          if (cnt_q != 3'd0) begin
            cnt_q <= cnt_q - 3'd1;
          end else begin
            state_q     <= ST_RESP;
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= is_store(op_q) ? 32'd0 : load_word;
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            state_q     <= ST_IDLE;
            rsp_valid_q <= 1'b0;
            req_ready_q <= 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Array is deliberately not reset; only the enabled lanes are written.
  always_ff @(posedge clk) begin
    if (rst_n && access && is_store(op_q)) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem_q[idx_q][8*b +: 8] <= store_word[8*b +: 8];
      end
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule

`default_nettype wire

// File: tb/tb_dmem_responder.sv
// ============================================================================
// tb_dmem_responder : vector table, corner sequences and random traffic vs a byte model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_dmem_responder;

  localparam int DEPTH = 64;
  localparam int WS    = 1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [5:0]  req_op = 6'd0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] mb [4*DEPTH];

  typedef struct {
    logic [5:0]  op;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        err;
    int          lat;
  } vec_t;

  vec_t vecs [16];

  dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(WS)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Byte-addressed reference: stores scatter bytes, loads gather the word and shift.
  function automatic void model(input logic [5:0] op, input logic [31:0] addr,
                                input logic [31:0] wd, output logic [31:0] rd,
                                output logic err, output int lat);
    logic        legal;
    int          size;
    logic [31:0] base;
    logic [31:0] word;
    legal = op inside {6'd0, 6'd1, 6'd2, 6'd3, 6'd4, 6'd15, 6'd16, 6'd17};
    size  = (op == 6'd0 || op == 6'd3 || op == 6'd15) ? 1 :
            (op == 6'd1 || op == 6'd4 || op == 6'd16) ? 2 : 4;
    err   = !legal || ((addr % size) != 0) || ((addr / 4) >= DEPTH);
    rd    = 32'd0;
    lat   = err ? 0 : 1 + WS;
    if (!err) begin
      if (op >= 6'd15) begin
        for (int k = 0; k < size; k++) mb[addr + k] = wd[8*k +: 8];
      end else begin
        base = addr & ~32'd3;
        word = {mb[base+3], mb[base+2], mb[base+1], mb[base]};
        rd   = word >> (8 * (addr % 4));
      end
    end
  endfunction

  task automatic txn(input logic [5:0] op, input logic [31:0] addr, input logic [31:0] wd,
                     output logic [31:0] rd, output logic e, output int lat);
    int n;
    @(negedge clk);
    req_valid = 1'b1; req_op = op; req_addr = addr; req_wdata = wd;
    n = 0;
    while (!req_ready && n < 50) begin @(negedge clk); n++; end
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 0;
    while (!rsp_valid && lat < 50) begin @(posedge clk); #1; lat++; end
    if (!rsp_valid) lat = -1;
    rd = rsp_rdata;
    e  = rsp_err;
    @(negedge clk); rsp_ready = 1'b1;
    @(posedge clk); #1; rsp_ready = 1'b0;
    chk("req_ready_after_rsp", 32'(req_ready), 32'd1);
  endtask

  function automatic vec_t mk(input logic [5:0] op, input logic [31:0] addr, input logic [31:0] wd,
                              input logic [31:0] rd, input logic e, input int lat);
    vec_t v;
    v.op = op; v.addr = addr; v.wdata = wd; v.rdata = rd; v.err = e; v.lat = lat;
    return v;
  endfunction

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_req_ready"}, 32'(req_ready), 32'd1);
    chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
    chk({tag, "_rsp_rdata"}, rsp_rdata, 32'd0);
    chk({tag, "_rsp_err"},   32'(rsp_err), 32'd0);
  endtask

  initial begin
    logic [31:0] rd, exp_rd, rd0;
    logic        e, exp_e, e0;
    int          lat, exp_lat, n;
    logic [5:0]  op;
    logic [31:0] addr, wd;
    logic [5:0]  legal_ops [8];
    legal_ops = '{6'd0, 6'd1, 6'd2, 6'd3, 6'd4, 6'd15, 6'd16, 6'd17};

    vecs[0]  = mk(6'd17, 32'h10, 32'hDEADBEEF, 32'h0,        1'b0, 2);
    vecs[1]  = mk(6'd2,  32'h10, 32'h0,        32'hDEADBEEF, 1'b0, 2);
    vecs[2]  = mk(6'd15, 32'h12, 32'h00000055, 32'h0,        1'b0, 2);
    vecs[3]  = mk(6'd2,  32'h10, 32'h0,        32'hDE55BEEF, 1'b0, 2);
    vecs[4]  = mk(6'd0,  32'h13, 32'h0,        32'h000000DE, 1'b0, 2);
    vecs[5]  = mk(6'd1,  32'h12, 32'h0,        32'h0000DE55, 1'b0, 2);
    vecs[6]  = mk(6'd3,  32'h11, 32'h0,        32'h00DE55BE, 1'b0, 2);
    vecs[7]  = mk(6'd1,  32'h11, 32'h0,        32'h0,        1'b1, 0);
    vecs[8]  = mk(6'd17, 32'h12, 32'h11111111, 32'h0,        1'b1, 0);
    vecs[9]  = mk(6'd2,  32'h10, 32'h0,        32'hDE55BEEF, 1'b0, 2);
    vecs[10] = mk(6'd9,  32'h10, 32'h0,        32'h0,        1'b1, 0);
    vecs[11] = mk(6'd2,  32'(4*DEPTH),   32'h0, 32'h0,       1'b1, 0);
    vecs[12] = mk(6'd17, 32'(4*DEPTH-4), 32'hCAFEF00D, 32'h0, 1'b0, 2);
    vecs[13] = mk(6'd2,  32'(4*DEPTH-4), 32'h0, 32'hCAFEF00D, 1'b0, 2);
    vecs[14] = mk(6'd16, 32'h12, 32'hAAAA1234, 32'h0,        1'b0, 2);
    vecs[15] = mk(6'd4,  32'h10, 32'h0,        32'h1234BEEF, 1'b0, 2);

    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    check_reset_outputs("post_reset");

    // Give every word a known value so random loads have a defined expectation.
    for (int w = 0; w < DEPTH; w++) begin
      wd = $urandom;
      model(6'd17, 32'(4*w), wd, exp_rd, exp_e, exp_lat);
      txn(6'd17, 32'(4*w), wd, rd, e, lat);
      if (w < 4) chk("init_err", 32'(e), 32'(exp_e));
    end

    for (int i = 0; i < 16; i++) begin
      model(vecs[i].op, vecs[i].addr, vecs[i].wdata, exp_rd, exp_e, exp_lat);
      txn(vecs[i].op, vecs[i].addr, vecs[i].wdata, rd, e, lat);
      chk($sformatf("vec%0d_rdata", i), rd, vecs[i].rdata);
      chk($sformatf("vec%0d_err", i),   32'(e), 32'(vecs[i].err));
      chk($sformatf("vec%0d_lat", i),   32'(lat), 32'(vecs[i].lat));
    end

    // Back-pressure with a second request queued behind the held response.
    model(6'd2, 32'h10, 32'h0, exp_rd, exp_e, exp_lat);
    @(negedge clk);
    req_valid = 1'b1; req_op = 6'd2; req_addr = 32'h10; req_wdata = 32'h0;
    @(posedge clk); #1;
    req_op = 6'd2; req_addr = 32'h14;
    n = 0;
    while (!rsp_valid && n < 50) begin @(posedge clk); #1; n++; end
    chk("bp_valid", 32'(rsp_valid), 32'd1);
    rd0 = rsp_rdata; e0 = rsp_err;
    chk("bp_rdata", rd0, exp_rd);
    chk("bp_err", 32'(e0), 32'(exp_e));
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      chk("bp_hold_valid", 32'(rsp_valid), 32'd1);
      chk("bp_hold_rdata", rsp_rdata, rd0);
      chk("bp_hold_err", 32'(rsp_err), 32'(e0));
      chk("bp_hold_ready", 32'(req_ready), 32'd0);
    end
    @(negedge clk); rsp_ready = 1'b1;
    @(posedge clk); #1; rsp_ready = 1'b0;
    chk("bp_idle_ready", 32'(req_ready), 32'd1);
    chk("bp_idle_valid", 32'(rsp_valid), 32'd0);
    @(posedge clk); #1;
    chk("bp_queued_accept", 32'(req_ready), 32'd0);
    req_valid = 1'b0;
    model(6'd2, 32'h14, 32'h0, exp_rd, exp_e, exp_lat);
    n = 0;
    while (!rsp_valid && n < 50) begin @(posedge clk); #1; n++; end
    chk("bp_queued_rdata", rsp_rdata, exp_rd);
    chk("bp_queued_err", 32'(rsp_err), 32'(exp_e));
    @(negedge clk); rsp_ready = 1'b1;
    @(posedge clk); #1; rsp_ready = 1'b0;

    // Reset during WAIT must drop the pending store.
    @(negedge clk);
    req_valid = 1'b1; req_op = 6'd17; req_addr = 32'h20; req_wdata = 32'h12345678;
    @(posedge clk); #1;
    req_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    @(posedge clk); #1;
    check_reset_outputs("midrst_hold");
    @(negedge clk); rst_n = 1'b1;
    model(6'd2, 32'h20, 32'h0, exp_rd, exp_e, exp_lat);
    txn(6'd2, 32'h20, 32'h0, rd, e, lat);
    chk("midrst_dropped_store", rd, exp_rd);
    chk("midrst_err", 32'(e), 32'd0);

    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(0, 9) == 9) op = 6'($urandom_range(0, 63));
      else op = legal_ops[$urandom_range(0, 7)];
      addr = 32'($urandom_range(0, 4*DEPTH + 15));
      if ($urandom_range(0, 3) != 0) addr[1:0] = 2'b00;
      if ($urandom_range(0, 19) == 0) addr = $urandom;
      wd = $urandom;
      model(op, addr, wd, exp_rd, exp_e, exp_lat);
      txn(op, addr, wd, rd, e, lat);
      chk($sformatf("rnd%0d_op%0d_a%0h_rdata", i, op, addr), rd, exp_rd);
      chk($sformatf("rnd%0d_err", i), 32'(e), 32'(exp_e));
      chk($sformatf("rnd%0d_lat", i), 32'(lat), 32'(exp_lat));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
